// File: rtl/fm_unpack_pkg.sv
// Shared widths, result-memory address constants and helpers for fm_unpack.
// SADDR_O_MEM / O_MEM_INCR mirror the feature-memory constants kept in define.v;
// they are only given a value here when that file has not already done so.
// Optional feature macro: FM_UNPACK_BYTEMASK_EN (partial byte enables on column tails).
`ifndef SADDR_O_MEM
`define SADDR_O_MEM 32'h4000_0000
`endif
`ifndef O_MEM_INCR
`define O_MEM_INCR 32'd4
`endif

package fm_unpack_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RADDR_W = 16;
  localparam int unsigned BADDR_W = 32;
  localparam int unsigned D64_W   = 64;
  localparam int unsigned D32_W   = 32;
  localparam int unsigned WE_W    = 4;

  localparam logic [BADDR_W-1:0] O_BASE = `SADDR_O_MEM;
  localparam logic [BADDR_W-1:0] O_INCR = `O_MEM_INCR;

  // One registered write beat towards the 32-bit result BRAM.
  typedef struct packed {
    logic [WE_W-1:0]    we;
    logic [BADDR_W-1:0] addr;
    logic [D32_W-1:0]   data;
  } wr_beat_t;

  // 32-bit words per column: four int8 elements per word, rounded up.
  function automatic logic [CNT_W-1:0] words_per_col(input logic [CNT_W-1:0] m);
    return CNT_W'((m - CNT_W'(1)) >> 2) + CNT_W'(1);
  endfunction

  // Byte enables for a column's final word holding only m%4 valid bytes.
  function automatic logic [WE_W-1:0] tail_mask(input logic [1:0] rem);
    logic [WE_W-1:0] mask;
    case (rem)
      2'd1:    mask = 4'b0001;
      2'd2:    mask = 4'b0011;
      2'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/unpack_addr_gen.sv
// Word/column counters and 64-bit read address generation for fm_unpack.
// The read port runs one word ahead of the consumer: the address register
// always holds the 64-bit word needed by the *next* WORK cycle, so the
// one-cycle BRAM latency is hidden and every WORK cycle sees its data.
module unpack_addr_gen
  import fm_unpack_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               com_i,
  input  logic               work_i,
  input  logic [CNT_W-1:0]   m_i,
  input  logic [CNT_W-1:0]   n_i,
  output logic               w_even_o,
  output logic               last_word_o,
  output logic               last_col_o,
  output logic [RADDR_W-1:0] raddr_o
);

  logic [CNT_W-1:0]   words_q, words_d;
  logic [CNT_W-1:0]   cols_q,  cols_d;
  logic [CNT_W-1:0]   w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]   c_cnt_q, c_cnt_d;
  logic [RADDR_W-1:0] raddr_q, raddr_d;
  logic               fetch_c;

  // Position flags for the word being handled this cycle.
  assign w_even_o    = ~w_cnt_q[0];
  assign last_word_o = (w_cnt_q == words_q - CNT_W'(1));
  assign last_col_o  = (c_cnt_q == cols_q - CNT_W'(1));
  assign raddr_o     = raddr_q;

  // Next counters; the fetch decision looks at the word index after the update.
  always_comb begin
    words_d = words_q;
    cols_d  = cols_q;
    w_cnt_d = w_cnt_q;
    c_cnt_d = c_cnt_q;
    raddr_d = raddr_q;
    fetch_c = 1'b0;

    if (com_i) begin
      words_d = words_per_col(m_i);
      cols_d  = n_i;
      w_cnt_d = '0;
      c_cnt_d = '0;
    end else if (work_i) begin
      if (last_word_o) begin
        w_cnt_d = '0;
        c_cnt_d = c_cnt_q + CNT_W'(1);
      end else begin
        w_cnt_d = w_cnt_q + CNT_W'(1);
      end
    end

    // Word after the upcoming one starts a new 64-bit word when the upcoming
    // one is odd (high half) or the last of its column (odd tail discarded).
    fetch_c = w_cnt_d[0] | (w_cnt_d == words_d - CNT_W'(1));

    if (start_i) begin
      raddr_d = '0;
    end else if (com_i || work_i) begin
      raddr_d = raddr_q + RADDR_W'(fetch_c);
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      cols_q  <= '0;
      w_cnt_q <= '0;
      c_cnt_q <= '0;
      raddr_q <= '0;
    end else begin
      words_q <= words_d;
      cols_q  <= cols_d;
      w_cnt_q <= w_cnt_d;
      c_cnt_q <= c_cnt_d;
      raddr_q <= raddr_d;
    end
  end

endmodule

// File: rtl/fm_unpack.sv
// fm_unpack: copies a result job from the 64-bit output buffer to the 32-bit
// PS-visible BRAM, low half of each 64-bit word first.
// Optional: define FM_UNPACK_BYTEMASK_EN to write only the valid bytes of the
// last word in each column when M is not a multiple of four.
module fm_unpack
  import fm_unpack_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   M,
  input  logic [CNT_W-1:0]   N,
  input  logic               unpack_start,
  output logic               unpack_finish,
  output logic [RADDR_W-1:0] BRAM_OUT64_raddr,
  input  logic [D64_W-1:0]   BRAM_OUT64_rddata,
  output logic [BADDR_W-1:0] BRAM_OUT32_addr,
  output logic               BRAM_OUT32_clk,
  output logic [D32_W-1:0]   BRAM_OUT32_wrdata,
  input  logic [D32_W-1:0]   BRAM_OUT32_rddata,
  output logic               BRAM_OUT32_en,
  output logic               BRAM_OUT32_rst,
  output logic [WE_W-1:0]    BRAM_OUT32_we
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_COM    = 4'b0010,
    ST_WORK   = 4'b0100,
    ST_FINISH = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic               finish_q, finish_d;
  logic               first_q, first_d;
  logic [D32_W-1:0]   hold_q, hold_d;
  wr_beat_t           wr_q, wr_d;

  logic               start_acc_c;
  logic               com_c;
  logic               work_c;
  logic               w_even_c;
  logic               last_word_c;
  logic               last_col_c;
  logic [D32_W-1:0]   data_c;
  logic [WE_W-1:0]    mask_c;
  logic               unused_rd32;

  assign start_acc_c = (state_q == ST_IDLE) && unpack_start;
  assign com_c       = (state_q == ST_COM);
  assign work_c      = (state_q == ST_WORK);

  unpack_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_acc_c),
    .com_i       (com_c),
    .work_i      (work_c),
    .m_i         (M),
    .n_i         (N),
    .w_even_o    (w_even_c),
    .last_word_o (last_word_c),
    .last_col_o  (last_col_c),
    .raddr_o     (BRAM_OUT64_raddr)
  );

  // Even words take the fresh low half; odd words reuse the held high half.
  assign data_c = w_even_c ? BRAM_OUT64_rddata[D32_W-1:0] : hold_q;

`ifdef FM_UNPACK_BYTEMASK_EN
  logic [1:0] rem_q, rem_d;

  // Remember M%4 for the column-tail byte mask.
  always_comb begin
    rem_d = rem_q;
    if (com_c) begin
      rem_d = M[1:0];
    end
  end

  // Tail-remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign mask_c = (last_word_c && (rem_q != 2'd0)) ? tail_mask(rem_q) : {WE_W{1'b1}};
`else
  assign mask_c = {WE_W{1'b1}};
`endif

  // Next state, finish flag, hold register and write beat.
  always_comb begin
    state_d  = state_q;
    finish_d = finish_q;
    first_d  = first_q;
    hold_d   = hold_q;
    wr_d     = wr_q;
    wr_d.we  = '0;

    case (state_q)
      ST_IDLE: begin
        if (unpack_start) begin
          state_d  = ST_COM;
          finish_d = 1'b0;
        end
      end
      ST_COM: begin
        first_d = 1'b1;
        if ((M == '0) || (N == '0)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WORK;
        end
      end
      ST_WORK: begin
        if (w_even_c) begin
          hold_d = BRAM_OUT64_rddata[D64_W-1:D32_W];
        end
        first_d   = 1'b0;
        wr_d.we   = mask_c;
        wr_d.addr = first_q ? O_BASE : (wr_q.addr + O_INCR);
        wr_d.data = data_c;
        if (last_word_c && last_col_c) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d  = ST_IDLE;
        finish_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      finish_q <= 1'b0;
      first_q  <= 1'b0;
      hold_q   <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish_d;
      first_q  <= first_d;
      hold_q   <= hold_d;
      wr_q     <= wr_d;
    end
  end

  assign unpack_finish     = finish_q;
  assign BRAM_OUT32_addr   = wr_q.addr;
  assign BRAM_OUT32_wrdata = wr_q.data;
  assign BRAM_OUT32_we     = wr_q.we;
  assign BRAM_OUT32_clk    = clk;
  assign BRAM_OUT32_en     = 1'b1;
  assign BRAM_OUT32_rst    = ~rst_n;

  // The result BRAM is write-only from this block.
  assign unused_rd32 = ^BRAM_OUT32_rddata;

endmodule

// File: tb/tb_fm_unpack.sv
// Bench for fm_unpack: 64-bit buffer model, queue-based write model and
// per-cycle write compare, plus literal expectations for the directed jobs.
`timescale 1ns/1ps
module tb_fm_unpack;
  import fm_unpack_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] m_in = '0;
  logic [15:0] n_in = '0;
  logic        unpack_start = 1'b0;
  logic        unpack_finish;
  logic [15:0] raddr64;
  logic [63:0] rddata64 = '0;
  logic [31:0] addr32;
  logic        clk32;
  logic [31:0] wrdata32;
  logic [31:0] rddata32 = 32'hDEAD_BEEF;
  logic        en32;
  logic        rst32;
  logic [3:0]  we32;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  we;
    int          at;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur_e;
  logic [31:0] got_data[$];
  logic [31:0] got_addr[$];
  logic [3:0]  got_we[$];
  logic [15:0] ra_seq[$];
  logic [63:0] mem[32];

  fm_unpack dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .M                 (m_in),
    .N                 (n_in),
    .unpack_start      (unpack_start),
    .unpack_finish     (unpack_finish),
    .BRAM_OUT64_raddr  (raddr64),
    .BRAM_OUT64_rddata (rddata64),
    .BRAM_OUT32_addr   (addr32),
    .BRAM_OUT32_clk    (clk32),
    .BRAM_OUT32_wrdata (wrdata32),
    .BRAM_OUT32_rddata (rddata32),
    .BRAM_OUT32_en     (en32),
    .BRAM_OUT32_rst    (rst32),
    .BRAM_OUT32_we     (we32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read 64-bit buffer: data one cycle after the address.
  always @(posedge clk) rddata64 <= (raddr64 < 16'd32) ? mem[raddr64[4:0]] : 64'h0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every write beat must match the next expected one, on its expected cycle.
  always @(negedge clk) begin
    if (rst_n && (we32 != 4'h0)) begin
      got_data.push_back(wrdata32);
      got_addr.push_back(addr32);
      got_we.push_back(we32);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h we %0h, required no write", addr32, wrdata32, we32);
      end else begin
        cur_e = expq.pop_front();
        chk("wr_data", 64'(wrdata32), 64'(cur_e.data));
        chk("wr_addr", 64'(addr32), 64'(cur_e.addr));
        chk("wr_we", 64'(we32), 64'(cur_e.we));
        chk("wr_cycle", 64'(cyc), 64'(cur_e.at));
      end
    end
  end

  // Expected write list for a job of M rows and N columns started at cycle s0.
  task automatic build_exp(input int m, input int n, input int s0);
    int words;
    int per;
    int k;
    logic [63:0] w64;
    exp_t e;
    words = (m + 3) / 4;
    per = (words + 1) / 2;
    k = 0;
    expq.delete();
    if (m > 0 && n > 0) begin
      for (int c = 0; c < n; c++) begin
        for (int w = 0; w < words; w++) begin
          w64 = mem[c * per + w / 2];
          e.data = (w % 2 == 0) ? w64[31:0] : w64[63:32];
          e.addr = O_BASE + 32'(4 * k);
`ifdef FM_UNPACK_BYTEMASK_EN
          e.we = (w == words - 1 && (m % 4) != 0) ? 4'((1 << (m % 4)) - 1) : 4'hF;
`else
          e.we = 4'hF;
`endif
          e.at = s0 + 3 + k;
          expq.push_back(e);
          k++;
        end
      end
    end
  endtask

  // Run one job to completion; dup_at>0 pulses start again in that job cycle.
  task automatic run_job(input int m, input int n, input int dup_at);
    int t;
    int s0;
    int fin;
    bit done;
    t = (m > 0 && n > 0) ? ((m + 3) / 4) * n : 0;
    got_data.delete();
    got_addr.delete();
    got_we.delete();
    ra_seq.delete();
    m_in = 16'(m);
    n_in = 16'(n);
    @(posedge clk); #1;
    unpack_start = 1'b1;
    s0 = cyc;
    build_exp(m, n, s0);
    @(posedge clk); #1;
    fin = -1;
    done = 1'b0;
    for (int i = 1; i < t + 40 && !done; i++) begin
      unpack_start = (i == dup_at);
      @(negedge clk);
      if (i == 1) chk("finish_cleared", 64'(unpack_finish), 64'd0);
      if (i <= t && (ra_seq.size() == 0 || ra_seq[$] != raddr64)) ra_seq.push_back(raddr64);
      if (unpack_finish) begin
        fin = i;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    unpack_start = 1'b0;
    chk("finish_cycle", 64'(fin), 64'(t + 3));
    repeat (3) @(posedge clk);
    #1;
    chk("writes_outstanding", 64'(expq.size()), 64'd0);
    chk("finish_held", 64'(unpack_finish), 64'd1);
  endtask

  int hits;

  initial begin
    mem[0] = 64'h1122_3344_AABB_CCDD;
    for (int i = 1; i < 32; i++) mem[i] = {32'hC000_0000 | 32'(i), 32'h5000_0000 | 32'(i)};

    // Reset values
    #12;
    chk("rst_finish", 64'(unpack_finish), 64'd0);
    chk("rst_raddr", 64'(raddr64), 64'd0);
    chk("rst_addr", 64'(addr32), 64'd0);
    chk("rst_wrdata", 64'(wrdata32), 64'd0);
    chk("rst_we", 64'(we32), 64'd0);
    chk("rst_bram_rst", 64'(rst32), 64'd1);
    chk("bram_en", 64'(en32), 64'd1);
    chk("bram_clk", 64'(clk32), 64'(clk));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // M=4 N=1: single write of the low half of word 0
    run_job(4, 1, 0);
    chk("m4_count", 64'(got_data.size()), 64'd1);
    chk("m4_data", 64'(got_data[0]), 64'h0000_0000_AABB_CCDD);
    chk("m4_addr", 64'(got_addr[0]), 64'(O_BASE));
    chk("m4_we", 64'(got_we[0]), 64'hF);

    // M=8 N=2 with a second start during WORK (ignored)
    run_job(8, 2, 3);
    chk("m8_count", 64'(got_data.size()), 64'd4);
    chk("m8_d0", 64'(got_data[0]), 64'hAABB_CCDD);
    chk("m8_d1", 64'(got_data[1]), 64'h1122_3344);
    chk("m8_d2", 64'(got_data[2]), 64'h5000_0001);
    chk("m8_d3", 64'(got_data[3]), 64'hC000_0001);
    chk("m8_a3", 64'(got_addr[3]), 64'(O_BASE + 32'd12));
    chk("m8_raddr_n", 64'(ra_seq.size()), 64'd2);
    chk("m8_raddr1", 64'(ra_seq[1]), 64'd1);

    // M=12 N=2: three words per column, high halves of words 1 and 3 dropped
    run_job(12, 2, 0);
    chk("m12_count", 64'(got_data.size()), 64'd6);
    chk("m12_raddr_n", 64'(ra_seq.size()), 64'd4);
    chk("m12_raddr0", 64'(ra_seq[0]), 64'd0);
    chk("m12_raddr3", 64'(ra_seq[3]), 64'd3);
    hits = 0;
    foreach (got_data[i]) if (got_data[i] == 32'hC000_0001 || got_data[i] == 32'hC000_0003) hits++;
    chk("m12_no_dropped_hi", 64'(hits), 64'd0);
    chk("m12_d4", 64'(got_data[4]), 64'hC000_0002);

    // M=5 N=1: tail byte mask only with the option enabled
    run_job(5, 1, 0);
    chk("m5_count", 64'(got_data.size()), 64'd2);
    chk("m5_we0", 64'(got_we[0]), 64'hF);
`ifdef FM_UNPACK_BYTEMASK_EN
    chk("m5_we1", 64'(got_we[1]), 64'h1);
`else
    chk("m5_we1", 64'(got_we[1]), 64'hF);
`endif

    // M=0 N=3: no writes, start during COM ignored
    run_job(0, 3, 1);
    chk("m0_count", 64'(got_data.size()), 64'd0);

    // Single-word columns and a larger shape
    run_job(1, 2, 0);
    chk("m1_d1", 64'(got_data[1]), 64'h5000_0001);
    run_job(16, 3, 0);
    chk("m16_count", 64'(got_data.size()), 64'd12);

    // Reset during WORK, then a fresh job from the base address
    m_in = 16'd8;
    n_in = 16'd4;
    @(posedge clk); #1;
    unpack_start = 1'b1;
    build_exp(8, 4, cyc);
    @(posedge clk); #1;
    unpack_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(we32), 64'd0);
    chk("mid_rst_finish", 64'(unpack_finish), 64'd0);
    chk("mid_rst_addr", 64'(addr32), 64'd0);
    chk("mid_rst_raddr", 64'(raddr64), 64'd0);
    expq.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_job(8, 4, 0);
    chk("rerun_addr0", 64'(got_addr[0]), 64'(O_BASE));
    chk("rerun_count", 64'(got_data.size()), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
